// File: rtl/ds18b20_pkg.sv
// Shared types and constants for the DS18B20 bus-side emulator.
// Scratchpad layout helper keeps the byte map in one place for reads and CRC.
package ds18b20_pkg;

  typedef enum logic [2:0] {
    IDLE,
    PRES_WAIT,
    PRESENCE,
    ROM_CMD,
    FUNC_CMD,
    CONV_POLL,
    READ_SP
  } state_t;

  localparam logic [7:0] CMD_SKIP_ROM = 8'hCC;
  localparam logic [7:0] CMD_CONVERT  = 8'h44;
  localparam logic [7:0] CMD_READ_SP  = 8'hBE;

  localparam logic [7:0] SP_TH   = 8'h4B;
  localparam logic [7:0] SP_TL   = 8'h46;
  localparam logic [7:0] SP_CFG  = 8'h7F;
  localparam logic [7:0] SP_RES0 = 8'hFF;
  localparam logic [7:0] SP_RES1 = 8'h0C;
  localparam logic [7:0] SP_RES2 = 8'h10;

  localparam logic [15:0] TEMP_POR = 16'h0550;

  function automatic logic [7:0] sp_byte(input logic [3:0] idx, input logic [15:0] temp,
                                         input logic [7:0] crc);
    logic [7:0] b;
    case (idx)
      4'd0:    b = temp[7:0];
      4'd1:    b = temp[15:8];
      4'd2:    b = SP_TH;
      4'd3:    b = SP_TL;
      4'd4:    b = SP_CFG;
      4'd5:    b = SP_RES0;
      4'd6:    b = SP_RES1;
      4'd7:    b = SP_RES2;
      default: b = crc;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/crc8_dallas.sv
// Serial Dallas/Maxim CRC8 (x^8+x^5+x^4+1, reflected), one data bit per enabled cycle.
module crc8_dallas (
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic       en,
  input  logic       din,
  output logic [7:0] crc
);

  logic [7:0] crc_q, crc_d;
  logic       fb;

  always_comb begin
    fb    = crc_q[0] ^ din;
    crc_d = crc_q;
    if (clr) begin
      crc_d = 8'h00;
    end else if (en) begin
      crc_d = {fb, crc_q[7:5], crc_q[4] ^ fb, crc_q[3] ^ fb, crc_q[2:1]};
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      crc_q <= 8'h00;
    end else begin
      crc_q <= crc_d;
    end
  end

  assign crc = crc_q;

endmodule

// File: rtl/ds18b20_responder.sv
// 1-Wire slave emulating a DS18B20: reset/presence, Skip ROM, Convert T and
// Read Scratchpad with a serially computed CRC8 over the first eight bytes.
module ds18b20_responder
  import ds18b20_pkg::*;
#(
  parameter int CLKS_PER_US   = 12,
  parameter int RESET_MIN_US  = 480,
  parameter int PRES_DELAY_US = 30,
  parameter int PRES_LEN_US   = 120,
  parameter int SAMPLE_US     = 30,
  parameter int CONV_US       = 750000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        I_ONE_WIRE,
  output logic        O_ONE_WIRE,
  input  logic [15:0] I_TEMP,
  output logic [7:0]  O_CMD,
  output logic        O_CMD_VALID,
  output logic        O_BUSY
);

  localparam int RESET_CYC  = RESET_MIN_US * CLKS_PER_US;
  localparam int PDLY_CYC   = PRES_DELAY_US * CLKS_PER_US;
  localparam int PLEN_CYC   = PRES_LEN_US * CLKS_PER_US;
  localparam int SAMPLE_CYC = SAMPLE_US * CLKS_PER_US;
  localparam int CONV_CYC   = CONV_US * CLKS_PER_US;
  localparam int LW = $clog2(RESET_CYC + 1);
  localparam int TW = $clog2(PDLY_CYC + PLEN_CYC + SAMPLE_CYC + 1);
  localparam int CW = $clog2(CONV_CYC + 1);

  localparam logic [LW-1:0] RESET_LAST  = LW'(RESET_CYC - 1);
  localparam logic [LW-1:0] RESET_SAT   = LW'(RESET_CYC);
  localparam logic [TW-1:0] PDLY_LAST   = TW'(PDLY_CYC - 1);
  localparam logic [TW-1:0] PLEN_LAST   = TW'(PLEN_CYC - 1);
  localparam logic [TW-1:0] SAMPLE_LAST = TW'(SAMPLE_CYC - 1);
  localparam logic [CW-1:0] CONV_LAST   = CW'(CONV_CYC - 1);

  logic          sync1_q, sync1_d, sync2_q, sync2_d, prev_q, prev_d;
  logic [LW-1:0] low_cnt_q, low_cnt_d;
  logic          rst_det_q, rst_det_d;
  state_t        state_q, state_d;
  logic [TW-1:0] tmr_q, tmr_d;
  logic          slot_q, slot_d;
  logic [7:0]    shift_q, shift_d;
  logic [2:0]    bit_q, bit_d;
  logic [3:0]    byte_q, byte_d;
  logic          drive_q, drive_d;
  logic [7:0]    cmd_q, cmd_d;
  logic          cmd_valid_q, cmd_valid_d;
  logic          busy_q, busy_d;
  logic [CW-1:0] conv_q, conv_d;
  logic [15:0]   temp_q, temp_d;
  logic          crc_run_q, crc_run_d, crc_done_q, crc_done_d;
  logic [5:0]    crc_cnt_q, crc_cnt_d;
  logic [7:0]    crc_q, crc_d, crc_snap_q, crc_snap_d;

  logic       fall, bus_reset_hit;
  logic       crc_clr, crc_din;
  logic [7:0] crc_res, crc_byte, rd_byte, rx_byte;
  logic       rd_bit;

  assign fall          = prev_q & ~sync2_q;
  assign bus_reset_hit = ~sync2_q && (low_cnt_q == RESET_LAST);

  crc8_dallas u_crc (
    .clk (clk),
    .rst (rst),
    .clr (crc_clr),
    .en  (crc_run_q),
    .din (crc_din),
    .crc (crc_res)
  );

  always_comb begin
    sync1_d     = I_ONE_WIRE;
    sync2_d     = sync1_q;
    prev_d      = sync2_q;
    low_cnt_d   = low_cnt_q;
    rst_det_d   = rst_det_q;
    state_d     = state_q;
    tmr_d       = tmr_q;
    slot_d      = slot_q;
    shift_d     = shift_q;
    bit_d       = bit_q;
    byte_d      = byte_q;
    drive_d     = drive_q;
    cmd_d       = cmd_q;
    cmd_valid_d = 1'b0;
    busy_d      = busy_q;
    conv_d      = conv_q;
    temp_d      = temp_q;
    crc_run_d   = crc_run_q;
    crc_cnt_d   = crc_cnt_q;
    crc_done_d  = 1'b0;
    crc_d       = crc_q;
    crc_snap_d  = crc_snap_q;
    crc_clr     = 1'b0;
    rx_byte     = {sync2_q, shift_q[7:1]};
    rd_byte     = sp_byte(byte_q, temp_q, crc_snap_q);
    rd_bit      = (state_q == CONV_POLL) ? ~busy_q : rd_byte[bit_q];
    crc_byte    = sp_byte({1'b0, crc_cnt_q[5:3]}, temp_q, 8'h00);
    crc_din     = crc_byte[crc_cnt_q[2:0]];

    if (sync2_q) begin
      low_cnt_d = '0;
    end else if (low_cnt_q != RESET_SAT) begin
      low_cnt_d = low_cnt_q + LW'(1);
    end

    if (crc_run_q) begin
      crc_cnt_d = crc_cnt_q + 6'd1;
      if (crc_cnt_q == 6'd63) begin
        crc_run_d  = 1'b0;
        crc_done_d = 1'b1;
      end
    end
    if (crc_done_q) begin
      crc_d = crc_res;
    end

    // Conversion keeps running through bus resets and any slot activity.
    if (busy_q) begin
      if (conv_q == '0) begin
        busy_d     = 1'b0;
        temp_d     = I_TEMP;
        crc_clr    = 1'b1;
        crc_run_d  = 1'b1;
        crc_cnt_d  = 6'd0;
        crc_done_d = 1'b0;
      end else begin
        conv_d = conv_q - CW'(1);
      end
    end

    if (bus_reset_hit) begin
      state_d   = IDLE;
      drive_d   = 1'b1;
      slot_d    = 1'b0;
      rst_det_d = 1'b1;
    end else if (rst_det_q) begin
      if (sync2_q) begin
        state_d   = PRES_WAIT;
        tmr_d     = '0;
        rst_det_d = 1'b0;
      end
    end else begin
      case (state_q)
        PRES_WAIT: begin
          tmr_d = tmr_q + TW'(1);
          if (tmr_q == PDLY_LAST) begin
            state_d = PRESENCE;
            tmr_d   = '0;
            drive_d = 1'b0;
          end
        end
        PRESENCE: begin
          tmr_d = tmr_q + TW'(1);
          if (tmr_q == PLEN_LAST) begin
            state_d = ROM_CMD;
            drive_d = 1'b1;
            slot_d  = 1'b0;
            bit_d   = 3'd0;
            shift_d = 8'h00;
          end
        end
        ROM_CMD, FUNC_CMD: begin
          if (!slot_q) begin
            if (fall) begin
              slot_d = 1'b1;
              tmr_d  = '0;
            end
          end else begin
            tmr_d = tmr_q + TW'(1);
            if (tmr_q == SAMPLE_LAST) begin
              slot_d  = 1'b0;
              shift_d = rx_byte;
              bit_d   = bit_q + 3'd1;
              if (bit_q == 3'd7) begin
                if (state_q == ROM_CMD) begin
                  state_d = (rx_byte == CMD_SKIP_ROM) ? FUNC_CMD : IDLE;
                end else begin
                  cmd_d       = rx_byte;
                  cmd_valid_d = 1'b1;
                  case (rx_byte)
                    CMD_CONVERT: begin
                      busy_d  = 1'b1;
                      conv_d  = CONV_LAST;
                      state_d = CONV_POLL;
                    end
                    CMD_READ_SP: begin
                      state_d    = READ_SP;
                      byte_d     = 4'd0;
                      bit_d      = 3'd0;
                      crc_snap_d = crc_q;
                    end
                    default: state_d = IDLE;
                  endcase
                end
              end
            end
          end
        end
        CONV_POLL, READ_SP: begin
          if (!slot_q) begin
            if (fall) begin
              slot_d  = 1'b1;
              tmr_d   = '0;
              drive_d = rd_bit;
            end
          end else begin
            tmr_d = tmr_q + TW'(1);
            if (tmr_q == SAMPLE_LAST) begin
              slot_d  = 1'b0;
              drive_d = 1'b1;
              if (state_q == READ_SP) begin
                bit_d = bit_q + 3'd1;
                if (bit_q == 3'd7) begin
                  if (byte_q == 4'd8) begin
                    state_d = IDLE;
                  end else begin
                    byte_d = byte_q + 4'd1;
                  end
                end
              end
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      sync1_q     <= 1'b1;
      sync2_q     <= 1'b1;
      prev_q      <= 1'b1;
      low_cnt_q   <= '0;
      rst_det_q   <= 1'b0;
      state_q     <= IDLE;
      tmr_q       <= '0;
      slot_q      <= 1'b0;
      shift_q     <= 8'h00;
      bit_q       <= 3'd0;
      byte_q      <= 4'd0;
      drive_q     <= 1'b1;
      cmd_q       <= 8'h00;
      cmd_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      conv_q      <= '0;
      temp_q      <= TEMP_POR;
      crc_run_q   <= 1'b1;
      crc_cnt_q   <= 6'd0;
      crc_done_q  <= 1'b0;
      crc_q       <= 8'h00;
      crc_snap_q  <= 8'h00;
    end else begin
      sync1_q     <= sync1_d;
      sync2_q     <= sync2_d;
      prev_q      <= prev_d;
      low_cnt_q   <= low_cnt_d;
      rst_det_q   <= rst_det_d;
      state_q     <= state_d;
      tmr_q       <= tmr_d;
      slot_q      <= slot_d;
      shift_q     <= shift_d;
      bit_q       <= bit_d;
      byte_q      <= byte_d;
      drive_q     <= drive_d;
      cmd_q       <= cmd_d;
      cmd_valid_q <= cmd_valid_d;
      busy_q      <= busy_d;
      conv_q      <= conv_d;
      temp_q      <= temp_d;
      crc_run_q   <= crc_run_d;
      crc_cnt_q   <= crc_cnt_d;
      crc_done_q  <= crc_done_d;
      crc_q       <= crc_d;
      crc_snap_q  <= crc_snap_d;
    end
  end

  assign O_ONE_WIRE  = drive_q;
  assign O_CMD       = cmd_q;
  assign O_CMD_VALID = cmd_valid_q;
  assign O_BUSY      = busy_q;

endmodule

// File: tb/tb_ds18b20_responder.sv
// Bench for ds18b20_responder: a timed 1-Wire master drives slots while independent
// monitors pop expected commands, bits, drive pulses and busy windows from queues.
module tb_ds18b20_responder;

  localparam int CLKS       = 4;
  localparam int CONV       = 1000;
  localparam int PDLY_CYC   = 30 * CLKS;
  localparam int PLEN_CYC   = 120 * CLKS;
  localparam int SAMPLE_CYC = 30 * CLKS;
  localparam int CONV_CYC   = CONV * CLKS;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        m_drv = 1'b1;
  logic [15:0] temp_in = 16'h0191;
  logic        o_ow, o_cmd_valid, o_busy, bus;
  logic [7:0]  o_cmd;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int rel_cyc = 0;

  logic       exp_bits[$];
  logic       exp_pulse[$];
  logic [7:0] exp_cmd[$];
  int         exp_busy[$];
  event       rd_ev;

  assign bus = m_drv & o_ow;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  ds18b20_responder #(
    .CLKS_PER_US (CLKS),
    .CONV_US     (CONV)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .I_ONE_WIRE  (bus),
    .O_ONE_WIRE  (o_ow),
    .I_TEMP      (temp_in),
    .O_CMD       (o_cmd),
    .O_CMD_VALID (o_cmd_valid),
    .O_BUSY      (o_busy)
  );

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end else begin
      $display("ok   %s: %0h", nm, act);
    end
  endtask

  task automatic chk_rng(input string nm, input int act, input int lo, input int hi);
    total++;
    if (act < lo || act > hi) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d..%0d (cycle %0d)", nm, act, lo, hi, cyc);
    end else begin
      $display("ok   %s: %0d", nm, act);
    end
  endtask

  function automatic logic [7:0] crc8_ref(input logic [63:0] d);
    logic [7:0] c;
    logic [7:0] b;
    logic       mix;
    c = 8'h00;
    for (int i = 0; i < 8; i++) begin
      b = d[i*8 +: 8];
      for (int j = 0; j < 8; j++) begin
        mix = c[0] ^ b[0];
        c = c >> 1;
        if (mix) c = c ^ 8'h8C;
        b = b >> 1;
      end
    end
    return c;
  endfunction

  task automatic wait_us(input int n);
    repeat (n * CLKS) @(negedge clk);
  endtask

  task automatic bus_reset();
    m_drv = 1'b0;
    wait_us(500);
    exp_pulse.push_back(1'b1);
    m_drv = 1'b1;
    rel_cyc = cyc;
    wait_us(170);
  endtask

  task automatic write_bit(input logic b);
    m_drv = 1'b0;
    wait_us(b ? 5 : 60);
    m_drv = 1'b1;
    wait_us(b ? 57 : 2);
  endtask

  task automatic write_byte(input logic [7:0] v);
    for (int i = 0; i < 8; i++) write_bit(v[i]);
  endtask

  task automatic read_bit(input logic e);
    exp_bits.push_back(e);
    if (!e) exp_pulse.push_back(1'b0);
    m_drv = 1'b0;
    wait_us(1);
    m_drv = 1'b1;
    wait_us(14);
    ->rd_ev;
    wait_us(47);
  endtask

  task automatic read_byte(input logic [7:0] v);
    for (int i = 0; i < 8; i++) read_bit(v[i]);
  endtask

  // Bit monitor: samples the responder's own drive at the master's sample point.
  initial begin
    logic e;
    forever begin
      @(rd_ev);
      if (exp_bits.size() == 0) begin
        chk("bit_unexpected", 1, 0);
      end else begin
        e = exp_bits.pop_front();
        chk("read_bit", int'(o_ow), int'(e));
      end
    end
  end

  initial begin
    logic [7:0] e;
    forever begin
      @(negedge clk);
      if (o_cmd_valid === 1'b1) begin
        if (exp_cmd.size() == 0) begin
          chk("cmd_unexpected", int'(o_cmd), -1);
        end else begin
          e = exp_cmd.pop_front();
          chk("cmd", int'(o_cmd), int'(e));
        end
        @(negedge clk);
        chk("cmd_valid_one_cycle", int'(o_cmd_valid), 0);
      end
    end
  end

  initial begin
    logic prev;
    int   start;
    prev = 1'b0;
    start = 0;
    forever begin
      @(negedge clk);
      if (o_busy === 1'b1 && !prev) start = cyc;
      if (o_busy === 1'b0 && prev) begin
        if (exp_busy.size() == 0) chk("busy_unexpected", cyc - start, -1);
        else chk_rng("busy_len", cyc - start, exp_busy[0] - 1, exp_busy.pop_front() + 1);
      end
      prev = o_busy;
    end
  end

  initial begin
    logic prev, kind;
    int   start;
    prev = 1'b1;
    start = 0;
    kind = 1'b0;
    forever begin
      @(negedge clk);
      if (o_ow === 1'b0 && prev) begin
        start = cyc;
        if (exp_pulse.size() == 0) begin
          chk("drive_unexpected", 0, 1);
          kind = 1'b0;
        end else begin
          kind = exp_pulse.pop_front();
          if (kind) chk_rng("pres_start", start - rel_cyc, PDLY_CYC + 2, PDLY_CYC + 4);
        end
      end
      if (o_ow === 1'b1 && !prev) begin
        if (kind) chk_rng("pres_len", cyc - start, PLEN_CYC - 1, PLEN_CYC + 1);
        else chk_rng("zero_len", cyc - start, SAMPLE_CYC - 1, SAMPLE_CYC + 1);
      end
      prev = o_ow;
    end
  end

  initial begin
    repeat (95000) @(posedge clk);
    $display("FAIL watchdog: run exceeded cycle budget");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] sp_lo;
    logic [7:0]  b2;
    sp_lo = 64'h100C_FF7F_464B_0191;
    b2 = 8'h4B;

    repeat (5) @(negedge clk);
    chk("rst_ow", int'(o_ow), 1);
    chk("rst_cmd", int'(o_cmd), 0);
    chk("rst_cmd_valid", int'(o_cmd_valid), 0);
    chk("rst_busy", int'(o_busy), 0);
    rst = 1'b1;
    wait_us(5);

    bus_reset();

    bus_reset();
    write_byte(8'hCC);
    exp_cmd.push_back(8'h44);
    exp_busy.push_back(CONV_CYC);
    write_byte(8'h44);
    read_bit(1'b0);
    read_bit(1'b0);
    wait_us(900);
    read_bit(1'b1);
    read_bit(1'b1);

    bus_reset();
    write_byte(8'hCC);
    exp_cmd.push_back(8'hBE);
    write_byte(8'hBE);
    for (int i = 0; i < 8; i++) read_byte(sp_lo[i*8 +: 8]);
    read_byte(crc8_ref(sp_lo));

    bus_reset();
    write_byte(8'h33);
    for (int i = 0; i < 16; i++) read_bit(1'b1);

    bus_reset();
    write_byte(8'hCC);
    exp_cmd.push_back(8'hBE);
    write_byte(8'hBE);
    read_byte(8'h91);
    read_byte(8'h01);
    for (int i = 0; i < 4; i++) read_bit(b2[i]);
    exp_bits.push_back(1'b0);
    exp_pulse.push_back(1'b0);
    m_drv = 1'b0;
    wait_us(15);
    ->rd_ev;
    wait_us(467);
    chk("abort_released", int'(o_ow), 1);
    wait_us(18);
    exp_pulse.push_back(1'b1);
    m_drv = 1'b1;
    rel_cyc = cyc;
    wait_us(170);

    chk("left_bits", exp_bits.size(), 0);
    chk("left_pulses", exp_pulse.size(), 0);
    chk("left_cmds", exp_cmd.size(), 0);
    chk("left_busy", exp_busy.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
